// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-side memory access controller.
//   state_t    : controller FSM states
//   RAM_*      : geometry of the 512x32 synchronous-read RAM
package mem_pkg;

  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DEPTH  = 512;
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    ERR,
    RESP
  } state_t;

endpackage : mem_pkg

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator for the 512x32
// synchronous-read RAM. Requests arrive from the MAR/MDR datapath on a
// valid/ready handshake; responses leave on a valid/ready handshake.
//
// Ports
//   clock, reset_n      : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_write           : 1 = store, 0 = load
//   req_addr            : 32-bit word address (>= MEM_DEPTH is an error)
//   req_wdata           : store data
//   resp_valid/ready    : response handshake (valid held until ready)
//   resp_rdata          : load data (0 for stores and errors)
//   resp_err            : address out of range, RAM untouched
//   ram_address         : RAM address (registered request address)
//   ram_read/ram_write  : RAM strobes, decoded from state only
//   ram_data_in         : RAM write data
//   ram_data_out        : RAM read data, valid the cycle after the address
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = WORD_W,
  parameter int MEM_DEPTH = RAM_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;

  logic accept;
  logic addr_bad;

  assign accept   = req_valid && (state == IDLE);
  assign addr_bad = (req_addr >= 32'(MEM_DEPTH));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request and read-data registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_r  <= '0;
      wdata_r <= '0;
      err_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      if (accept) begin
        addr_r  <= req_addr[ADDR_W-1:0];
        wdata_r <= req_wdata;
        err_r   <= addr_bad;
      end
      case (state)
        WR, ERR: rdata_r <= '0;
        RD_DATA: rdata_r <= ram_data_out;
        default: ;
      endcase
    end
  end

  // Next-state logic; the error decision uses the live address because
  // err_r is only being loaded on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (addr_bad)       state_nxt = ERR;
          else if (req_write) state_nxt = WR;
          else                state_nxt = RD_ADDR;
        end
      end
      WR:      state_nxt = RESP;
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: state_nxt = RESP;
      ERR:     state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    ram_read   = 1'b0;
    ram_write  = 1'b0;
    case (state)
      IDLE:             req_ready = 1'b1;
      WR:               ram_write = 1'b1;
      RD_ADDR, RD_DATA: ram_read  = 1'b1;
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_r;
        resp_err   = err_r;
      end
      default: ;
    endcase
  end

  assign ram_address = addr_r;
  assign ram_data_in = wdata_r;

endmodule : mem_access_ctrl
